// File: rtl/sa_autosa_sdp_rdma_grp_ctrl.sv
// sa_autosa_sdp_rdma_grp_ctrl
// Dual register-group sequencer for the SDP RDMA. Tracks IDLE/PENDING/RUNNING
// per group, owns the consumer pointer, and launches the read engine for the
// group that consumer points at once the core is idle.
// Optional feature macro: SA_AUTOSA_SDP_RDMA_GRP_PERF_EN adds per-group
// run-cycle counters (perf_run_cnt_0/1, width PERF_CNT_W).
module sa_autosa_sdp_rdma_grp_ctrl
`ifdef SA_AUTOSA_SDP_RDMA_GRP_PERF_EN
#(
  parameter int PERF_CNT_W = 32
)
`endif
(
  input  logic       autosa_core_clk,
  input  logic       autosa_core_rstn,
  input  logic       producer,
  input  logic       op_en_wr,
  input  logic       op_en_wr_data,
  input  logic       op_done,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic       grp0_op_en,
  output logic       grp1_op_en,
  output logic       core_op_en,
  output logic       op_start,
  output logic       done_intr_0,
  output logic       done_intr_1
`ifdef SA_AUTOSA_SDP_RDMA_GRP_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_run_cnt_0,
  output logic [PERF_CNT_W-1:0] perf_run_cnt_1
`endif
);

  typedef enum logic [1:0] {
    GRP_IDLE    = 2'b00,
    GRP_RUNNING = 2'b01,
    GRP_PENDING = 2'b10
  } grp_st_e;

  grp_st_e st0_r, st1_r;
  grp_st_e st0_nxt_s, st1_nxt_s;
  logic    consumer_r, consumer_nxt_s;
  logic    any_running_s;
  logic    start0_s, start1_s;
  logic    grp0_op_en_r, grp1_op_en_r, core_op_en_r, op_start_r;
  logic    done_intr_0_r, done_intr_1_r;

  // Per-group transition rule. A completing layer is retired first, so an
  // enable write landing on the done cycle re-arms the group as PENDING.
  function automatic grp_st_e grp_next(input grp_st_e cur, input logic wr,
                                       input logic data, input logic sel,
                                       input logic busy, input logic done);
    grp_st_e nxt;
    case (cur)
      GRP_IDLE: begin
        if (wr && data) nxt = GRP_PENDING;
        else            nxt = GRP_IDLE;
      end
      GRP_PENDING: begin
        if (wr && !data)                nxt = GRP_IDLE;
        else if (sel && !busy && !done) nxt = GRP_RUNNING;
        else                            nxt = GRP_PENDING;
      end
      GRP_RUNNING: begin
        if (done && wr && data) nxt = GRP_PENDING;
        else if (done)          nxt = GRP_IDLE;
        else                    nxt = GRP_RUNNING;
      end
      default: nxt = GRP_IDLE;
    endcase
    return nxt;
  endfunction

  // Next-state, consumer update and launch detection for both groups.
  always_comb begin
    any_running_s  = (st0_r == GRP_RUNNING) || (st1_r == GRP_RUNNING);
    st0_nxt_s      = grp_next(st0_r, op_en_wr && (producer == 1'b0), op_en_wr_data,
                              consumer_r == 1'b0, any_running_s, op_done);
    st1_nxt_s      = grp_next(st1_r, op_en_wr && (producer == 1'b1), op_en_wr_data,
                              consumer_r == 1'b1, any_running_s, op_done);
    // Only the consumer group can be running, so completion always flips it.
    if (op_done && any_running_s) consumer_nxt_s = ~consumer_r;
    else                          consumer_nxt_s = consumer_r;
    start0_s = (st0_nxt_s == GRP_RUNNING) && (st0_r != GRP_RUNNING);
    start1_s = (st1_nxt_s == GRP_RUNNING) && (st1_r != GRP_RUNNING);
  end

  // State, consumer pointer and registered status-derived outputs.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      st0_r         <= GRP_IDLE;
      st1_r         <= GRP_IDLE;
      consumer_r    <= 1'b0;
      grp0_op_en_r  <= 1'b0;
      grp1_op_en_r  <= 1'b0;
      core_op_en_r  <= 1'b0;
      op_start_r    <= 1'b0;
      done_intr_0_r <= 1'b0;
      done_intr_1_r <= 1'b0;
    end else begin
      st0_r         <= st0_nxt_s;
      st1_r         <= st1_nxt_s;
      consumer_r    <= consumer_nxt_s;
      grp0_op_en_r  <= (st0_nxt_s != GRP_IDLE);
      grp1_op_en_r  <= (st1_nxt_s != GRP_IDLE);
      core_op_en_r  <= (st0_nxt_s == GRP_RUNNING) || (st1_nxt_s == GRP_RUNNING);
      op_start_r    <= start0_s || start1_s;
      done_intr_0_r <= op_done && (st0_r == GRP_RUNNING);
      done_intr_1_r <= op_done && (st1_r == GRP_RUNNING);
    end
  end

  assign consumer    = consumer_r;
  assign status_0    = st0_r;
  assign status_1    = st1_r;
  assign grp0_op_en  = grp0_op_en_r;
  assign grp1_op_en  = grp1_op_en_r;
  assign core_op_en  = core_op_en_r;
  assign op_start    = op_start_r;
  assign done_intr_0 = done_intr_0_r;
  assign done_intr_1 = done_intr_1_r;

`ifdef SA_AUTOSA_SDP_RDMA_GRP_PERF_EN
  logic [PERF_CNT_W-1:0] perf0_r, perf1_r;
  localparam logic [PERF_CNT_W-1:0] PERF_MAX = {PERF_CNT_W{1'b1}};
  localparam logic [PERF_CNT_W-1:0] PERF_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

  // Run-cycle counters: zeroed at launch, saturating count while running.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      perf0_r <= {PERF_CNT_W{1'b0}};
      perf1_r <= {PERF_CNT_W{1'b0}};
    end else begin
      if (start0_s)                                        perf0_r <= {PERF_CNT_W{1'b0}};
      else if ((st0_r == GRP_RUNNING) && (perf0_r != PERF_MAX)) perf0_r <= perf0_r + PERF_ONE;
      else                                                 perf0_r <= perf0_r;
      if (start1_s)                                        perf1_r <= {PERF_CNT_W{1'b0}};
      else if ((st1_r == GRP_RUNNING) && (perf1_r != PERF_MAX)) perf1_r <= perf1_r + PERF_ONE;
      else                                                 perf1_r <= perf1_r;
    end
  end

  assign perf_run_cnt_0 = perf0_r;
  assign perf_run_cnt_1 = perf1_r;
`endif

endmodule

// File: tb/tb_sa_autosa_sdp_rdma_grp_ctrl.sv
// Directed self-checking bench for sa_autosa_sdp_rdma_grp_ctrl.
// Define SA_AUTOSA_SDP_RDMA_GRP_PERF_EN to also exercise the run counters.
module tb_sa_autosa_sdp_rdma_grp_ctrl;

  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_R = 2'b01;
  localparam logic [1:0] S_P = 2'b10;

  logic       autosa_core_clk = 1'b0;
  logic       autosa_core_rstn;
  logic       producer, op_en_wr, op_en_wr_data, op_done;
  logic       consumer, grp0_op_en, grp1_op_en, core_op_en, op_start;
  logic       done_intr_0, done_intr_1;
  logic [1:0] status_0, status_1;
`ifdef SA_AUTOSA_SDP_RDMA_GRP_PERF_EN
  logic [31:0] perf_run_cnt_0, perf_run_cnt_1;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sa_autosa_sdp_rdma_grp_ctrl dut (
    .autosa_core_clk (autosa_core_clk),
    .autosa_core_rstn(autosa_core_rstn),
    .producer        (producer),
    .op_en_wr        (op_en_wr),
    .op_en_wr_data   (op_en_wr_data),
    .op_done         (op_done),
    .consumer        (consumer),
    .status_0        (status_0),
    .status_1        (status_1),
    .grp0_op_en      (grp0_op_en),
    .grp1_op_en      (grp1_op_en),
    .core_op_en      (core_op_en),
    .op_start        (op_start),
    .done_intr_0     (done_intr_0),
    .done_intr_1     (done_intr_1)
`ifdef SA_AUTOSA_SDP_RDMA_GRP_PERF_EN
    ,
    .perf_run_cnt_0  (perf_run_cnt_0),
    .perf_run_cnt_1  (perf_run_cnt_1)
`endif
  );

  always #5 autosa_core_clk = ~autosa_core_clk;

  // Apply one cycle of inputs, let the edge happen, then return the pulses to 0.
  task automatic cyc(input logic w, input logic p, input logic d, input logic dn);
    producer      = p;
    op_en_wr      = w;
    op_en_wr_data = d;
    op_done       = dn;
    @(posedge autosa_core_clk);
    #1;
    op_en_wr      = 1'b0;
    op_en_wr_data = 1'b0;
    op_done       = 1'b0;
  endtask

  // Compare every non-perf output against the expected group states and pulses.
  task automatic chk(input string tag, input logic [1:0] e_s0, input logic [1:0] e_s1,
                     input logic e_cons, input logic e_core, input logic e_start,
                     input logic e_di0, input logic e_di1);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {consumer, status_1, status_0, grp1_op_en, grp0_op_en, core_op_en,
           op_start, done_intr_1, done_intr_0};
    exp = {e_cons, e_s1, e_s0, (e_s1 != 2'b00), (e_s0 != 2'b00), e_core,
           e_start, e_di1, e_di0};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

`ifdef SA_AUTOSA_SDP_RDMA_GRP_PERF_EN
  task automatic chk_perf(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    producer = 1'b0; op_en_wr = 1'b0; op_en_wr_data = 1'b0; op_done = 1'b0;
    autosa_core_rstn = 1'b0;
    #1;
    chk("reset", S_I, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #13;
    autosa_core_rstn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_after_reset", S_I, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Enable group 0 while it is the consumer and the core is idle.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("g0_pending", S_P, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("g0_start", S_R, S_I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("g0_running", S_R, S_I, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Queue group 1 behind the running group 0, then complete group 0.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("g1_queued", S_R, S_P, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("g1_waits", S_R, S_P, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("g0_done_gap", S_I, S_P, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("g1_start", S_I, S_R, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("g1_done", S_I, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("all_idle", S_I, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Group 1 enabled while consumer=0: stays pending, re-enable no effect, cancel.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("g1_pend_notcons", S_I, S_P, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("g1_still_pending", S_I, S_P, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("g1_reenable_noeff", S_I, S_P, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("g1_cancel", S_I, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Done and re-enable of the same running group in one cycle.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("g0_run_again", S_R, S_I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("done_plus_enable", S_P, S_I, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("g0_pend_no_start", S_P, S_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("g1_runs_first", S_P, S_R, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("g1_done_b", S_P, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("g0_resumes", S_R, S_I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("g0_done_b", S_I, S_I, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Spurious done while idle is ignored.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("done_idle_ignored", S_I, S_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_idle_noint", S_I, S_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Writes to a running group (cancel or enable) are ignored.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("g1_run_c", S_I, S_R, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("cancel_running_ign", S_I, S_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("enable_running_ign", S_I, S_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("g1_done_c", S_I, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SA_AUTOSA_SDP_RDMA_GRP_PERF_EN
    // Group 0 runs 100 cycles; counter reads 100 after done and holds.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("perf_at_start", perf_run_cnt_0, 32'd0);
    for (int i = 0; i < 99; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("perf_99", perf_run_cnt_0, 32'd99);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_perf("perf_100", perf_run_cnt_0, 32'd100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("perf_hold", perf_run_cnt_0, 32'd100);
    chk_perf("perf1_untouched", perf_run_cnt_1, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_perf("perf1_run", perf_run_cnt_1, 32'd5);
`else
    // Leave group 0 running so the reset below lands mid-layer.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("g0_run_d", S_R, S_I, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a running layer.
    #2;
    autosa_core_rstn = 1'b0;
    #1;
    chk("midrun_reset", S_I, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SA_AUTOSA_SDP_RDMA_GRP_PERF_EN
    chk_perf("perf_reset", perf_run_cnt_1, 32'd0);
`endif
    @(negedge autosa_core_clk);
    autosa_core_rstn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_noint", S_I, S_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_autosa_sdp_rdma_grp_ctrl.md
# sa_autosa_sdp_rdma_grp_ctrl

Dual-register-group sequencer for the SDP RDMA. It consumes the software-owned `producer` pointer and op-enable writes, and arbitrates which of the two register groups the RDMA datapath executes. It generates the `consumer`, `status_0` and `status_1` values read back through the single-register block. It sits between the SDP RDMA register file and the RDMA read-engine launch logic.

## Interface
Parameters:
- PERF_CNT_W, 32, width of per-group run-cycle counters (used only when the perf feature is compiled in).

Ports:
- autosa_core_clk  input  1  core clock.
- autosa_core_rstn  input  1  asynchronous, active-low reset; clock is autosa_core_clk.
- producer  input  1  group currently targeted by software writes.
- op_en_wr  input  1  one-cycle pulse: software wrote D_OP_ENABLE of group `producer`.
- op_en_wr_data  input  1  value written with op_en_wr (1 = enable, 0 = cancel).
- op_done  input  1  one-cycle pulse from the datapath: the running layer completed.
- consumer  output  1  group the datapath executes next or currently.
- status_0  output  2  group 0 state: 00 IDLE, 01 RUNNING, 10 PENDING.
- status_1  output  2  group 1 state, same encoding.
- grp0_op_en  output  1  D_OP_ENABLE readback for group 0; equals (status_0 != IDLE).
- grp1_op_en  output  1  D_OP_ENABLE readback for group 1; equals (status_1 != IDLE).
- core_op_en  output  1  level, high while either group is RUNNING.
- op_start  output  1  one-cycle pulse on each entry into RUNNING.
- done_intr_0  output  1  one-cycle pulse after group 0 completes.
- done_intr_1  output  1  one-cycle pulse after group 1 completes.
- perf_run_cnt_0  output  PERF_CNT_W  only with perf feature compiled in.
- perf_run_cnt_1  output  PERF_CNT_W  only with perf feature compiled in.

## Operation
- Each group has an independent 3-state FSM: IDLE, PENDING, RUNNING. Encoding 2'b11 is unreachable.
- The `consumer` bit is registered.
- IDLE → PENDING: op_en_wr=1 with op_en_wr_data=1 and producer=g.
- PENDING → IDLE: op_en_wr=1 with op_en_wr_data=0 and producer=g (cancel).
- PENDING → RUNNING: consumer=g, no group RUNNING, and no op_done this cycle.
- RUNNING → IDLE: op_done=1.
  - consumer toggles on the same edge.
  - done_intr_g pulses in the following cycle.
- op_en_wr to a RUNNING group: data=1 is ignored; data=0 is ignored, because a running layer cannot be cancelled.
- op_en_wr data=1 to a PENDING group: no effect.
- op_done in the same cycle as an enable write to the same (RUNNING) group: the group ends in PENDING. Done is processed first; then the enable applies. done_intr still fires.
- op_done with no group RUNNING: ignored. consumer is unchanged and no interrupt fires.
- At most one group is RUNNING at any time, and only the group equal to consumer can be RUNNING.
- core_op_en is asserted exactly while a status is RUNNING.
- op_start pulses in the first cycle a status reads RUNNING.

## Timing
- Reset values: consumer=0, status_0=status_1=00, grp*_op_en=0, core_op_en=0, op_start=0, done_intr_*=0, perf counters=0.
- Enable write sampled at edge k: status reads PENDING after edge k.
- If consumer=g and the core is idle: RUNNING after edge k+1; op_start and core_op_en are high in the cycle after edge k+1.
- op_done sampled at edge m: the group reads IDLE, consumer toggles and core_op_en drops after edge m.
- If the other group is PENDING, it reads RUNNING after edge m+1. There is a guaranteed minimum one-cycle core_op_en low gap between layers.
- Reset asserted mid-operation: all state clears immediately (asynchronously). A RUNNING layer is abandoned with no done_intr.

## Configuration
- SA_AUTOSA_SDP_RDMA_GRP_PERF_EN defined:
  - perf_run_cnt_g clears to 0 on entry to RUNNING for group g.
  - It increments each cycle that group g is RUNNING.
  - It saturates at all-ones and holds its value while not RUNNING.
- Not defined: the counters and ports do not exist; all other behaviour is identical.

## Test plan
- Reset, then producer=0, enable write data=1 → status_0=10 for one cycle, then 01. op_start pulses once; consumer=0.
- Group 0 running; producer=1, enable write → status_1=10. op_done → status_0=00, consumer=1, done_intr_0 pulse. Next cycle status_1=01 and core_op_en has one low cycle.
- producer=1, enable group 1 while consumer=0 and nothing running → group 1 stays PENDING indefinitely. Cancel write data=0 → status_1=00.
- Group 0 RUNNING; in the same cycle op_done=1 and enable write (producer=0, data=1) → status_0=10, consumer=1, done_intr_0 pulse. No op_start until group 1 completes or consumer returns to 0.
- op_done with both groups IDLE → no change; consumer stays 0 and there are no interrupts. Cancel a RUNNING group → ignored, stays 01.
- With SA_AUTOSA_SDP_RDMA_GRP_PERF_EN: group 0 running 100 cycles → perf_run_cnt_0=100, held after done. Reset mid-run → counter=0, status=00.
